// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped cache and its backing-memory responder.
package cache_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 5;
    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned CNT_W          = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    function automatic int unsigned mem_depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/resp_mem_array.sv
// Word storage for the responder: synchronous write, registered read, async clear of all words.
module resp_mem_array
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned Depth = mem_depth(ADDR_W);

    logic [DATA_W-1:0] mem_q [Depth];
    logic [DATA_W-1:0] rdata_q;

    // rdata_q only moves on a read, so it holds the last read result across writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we) begin
                mem_q[addr] <= wdata;
            end
            if (re) begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Fixed-latency backing memory for the cache: one request at a time, ready/req accept,
// one-cycle rvalid (read) or wack (write) pulse LATENCY cycles after the accept edge.
module cache_mem_responder
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned LATENCY = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              wack
);

    localparam logic [CNT_W-1:0] CntLoad = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              rvalid_q, rvalid_d;
    logic              wack_q, wack_d;
    logic              latch_en;
    logic              mem_we, mem_re;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            wack_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            if (latch_en) begin
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rvalid_d = 1'b0;
        wack_d   = 1'b0;
        latch_en = 1'b0;
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    latch_en = 1'b1;
                    cnt_d    = CntLoad;
                    state_d  = StWait;
                end
            end
            StWait: begin
                // The access and its response pulse are launched on the same edge.
                if (cnt_q == '0) begin
                    mem_we   = wr_q;
                    mem_re   = ~wr_q;
                    rvalid_d = ~wr_q;
                    wack_d   = wr_q;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    resp_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (addr_q),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign ready  = (state_q == StIdle);
    assign rvalid = rvalid_q;
    assign wack   = wack_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Directed bench for cache_mem_responder at LATENCY 3, 1 and 15.
`timescale 1ns/1ps
module tb_cache_mem_responder;

    logic        clk;
    logic        rst;
    logic        req_s    [3];
    logic        wr_s     [3];
    logic [4:0]  addr_s   [3];
    logic [31:0] wdata_s  [3];
    logic        ready_s  [3];
    logic        rvalid_s [3];
    logic [31:0] rdata_s  [3];
    logic        wack_s   [3];

    int checks   = 0;
    int failures = 0;
    int viol     = 0;
    int rv_cnt [3];
    int wk_cnt [3];
    bit prev_p [3];

    cache_mem_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .req(req_s[0]), .wr(wr_s[0]), .addr(addr_s[0]),
        .wdata(wdata_s[0]), .ready(ready_s[0]), .rvalid(rvalid_s[0]), .rdata(rdata_s[0]),
        .wack(wack_s[0])
    );
    cache_mem_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .req(req_s[1]), .wr(wr_s[1]), .addr(addr_s[1]),
        .wdata(wdata_s[1]), .ready(ready_s[1]), .rvalid(rvalid_s[1]), .rdata(rdata_s[1]),
        .wack(wack_s[1])
    );
    cache_mem_responder #(.ADDR_W(5), .DATA_W(32), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst), .req(req_s[2]), .wr(wr_s[2]), .addr(addr_s[2]),
        .wdata(wdata_s[2]), .ready(ready_s[2]), .rvalid(rvalid_s[2]), .rdata(rdata_s[2]),
        .wack(wack_s[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse protocol: never both, never two cycles running.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rvalid_s[i] && wack_s[i]) viol++;
            if ((rvalid_s[i] || wack_s[i]) && prev_p[i]) viol++;
            prev_p[i] = rvalid_s[i] || wack_s[i];
            if (rvalid_s[i]) rv_cnt[i]++;
            if (wack_s[i]) wk_cnt[i]++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input int d, input string tag);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready_s[d] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_ready"}, 64'(ready_s[d]), 64'd1);
    endtask

    // Called just after an edge; returns number of further edges until a pulse is seen.
    task automatic wait_pulse(input int d, output int n);
        n = 0;
        while (!(rvalid_s[d] || wack_s[d]) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic txn(input int d, input int lat, input logic w, input logic [4:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input string tag);
        int n;
        wait_ready(d, tag);
        req_s[d] = 1'b1; wr_s[d] = w; addr_s[d] = a; wdata_s[d] = wd;
        @(posedge clk);
        #1;
        // Inputs only matter at the accept edge; scramble them afterwards.
        req_s[d] = 1'b0; wr_s[d] = ~w; addr_s[d] = ~a; wdata_s[d] = ~wd;
        check({tag, "_busy"}, 64'(ready_s[d]), 64'd0);
        wait_pulse(d, n);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_kind"}, 64'({rvalid_s[d], wack_s[d], ready_s[d]}),
              w ? 64'b010 : 64'b100);
        check({tag, "_rdata"}, 64'(rdata_s[d]), 64'(exp_rd));
        @(posedge clk);
        #1;
        check({tag, "_done"}, 64'({rvalid_s[d], wack_s[d], ready_s[d]}), 64'b001);
    endtask

    initial begin
        int n;
        int wk0;
        int rv0;
        longint t_prev;
        longint t_acc;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = '0; wdata_s[i] = '0;
            rv_cnt[i] = 0; wk_cnt[i] = 0; prev_p[i] = 1'b0;
        end
        t_prev = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_s[0]), 64'd1);
        check("rst_rvalid", 64'(rvalid_s[0]), 64'd0);
        check("rst_wack", 64'(wack_s[0]), 64'd0);
        check("rst_rdata", 64'(rdata_s[0]), 64'd0);

        txn(0, 3, 1'b0, 5'd7, 32'h0, 32'h0, "rd7");
        txn(0, 3, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, "wr5");
        txn(0, 3, 1'b0, 5'd5, 32'h0, 32'hDEADBEEF, "rd5");

        // Back-to-back with req held high: write 1, read, write 2, read.
        rv0 = rv_cnt[0];
        wk0 = wk_cnt[0];
        for (int i = 0; i < 4; i++) begin
            wait_ready(0, "b2b");
            req_s[0] = 1'b1; wr_s[0] = (i % 2 == 0); addr_s[0] = 5'd0;
            wdata_s[0] = 32'(i / 2 + 1);
            @(posedge clk);
            t_acc = $time;
            if (i > 0) check("b2b_gap", 64'((t_acc - t_prev) / 10), 64'd5);
            t_prev = t_acc;
            #1;
            wait_pulse(0, n);
            check("b2b_lat", 64'(n), 64'd3);
            if (i % 2 == 1) check("b2b_rdata", 64'(rdata_s[0]), 64'(i / 2 + 1));
            else check("b2b_wack", 64'(wack_s[0]), 64'd1);
        end
        @(negedge clk);
        req_s[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("b2b_rv_count", 64'(rv_cnt[0] - rv0), 64'd2);
        check("b2b_wk_count", 64'(wk_cnt[0] - wk0), 64'd2);

        // Write request issued while busy must be dropped.
        wk0 = wk_cnt[0];
        wait_ready(0, "busy");
        req_s[0] = 1'b1; wr_s[0] = 1'b0; addr_s[0] = 5'd7;
        @(posedge clk);
        #1;
        req_s[0] = 1'b0;
        @(negedge clk);
        req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 5'd3; wdata_s[0] = 32'hAA;
        @(negedge clk);
        req_s[0] = 1'b0; wr_s[0] = 1'b0;
        wait_pulse(0, n);
        check("busy_kind", 64'({rvalid_s[0], wack_s[0]}), 64'b10);
        repeat (4) @(posedge clk);
        #1;
        check("busy_no_wack", 64'(wk_cnt[0] - wk0), 64'd0);
        txn(0, 3, 1'b0, 5'd3, 32'h0, 32'h0, "rd3");

        // Reset during the wait phase of a write.
        wk0 = wk_cnt[0];
        wait_ready(0, "rstw");
        req_s[0] = 1'b1; wr_s[0] = 1'b1; addr_s[0] = 5'd9; wdata_s[0] = 32'h55;
        @(posedge clk);
        #1;
        req_s[0] = 1'b0; wr_s[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_ready", 64'(ready_s[0]), 64'd1);
        @(posedge clk);
        #1;
        check("rstw_pulse", 64'({rvalid_s[0], wack_s[0]}), 64'b00);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstw_no_wack", 64'(wk_cnt[0] - wk0), 64'd0);
        check("rstw_rdata", 64'(rdata_s[0]), 64'd0);
        txn(0, 3, 1'b0, 5'd9, 32'h0, 32'h0, "rd9");
        txn(0, 3, 1'b0, 5'd5, 32'h0, 32'h0, "rd5_cleared");

        // Latency extremes, top address.
        txn(1, 1, 1'b1, 5'd31, 32'hCAFEF00D, 32'h0, "l1_wr31");
        txn(1, 1, 1'b0, 5'd31, 32'h0, 32'hCAFEF00D, "l1_rd31");
        txn(2, 15, 1'b1, 5'd31, 32'h12345678, 32'h0, "l15_wr31");
        txn(2, 15, 1'b0, 5'd31, 32'h0, 32'h12345678, "l15_rd31");
        txn(2, 15, 1'b0, 5'd0, 32'h0, 32'h0, "l15_rd0");

        check("pulse_protocol", 64'(viol), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_mem_responder.md
# cache_mem_responder

Backing-memory responder for the direct-mapped cache: it sits on the memory side of the cache's miss/fill and write-through port and serves one request at a time after a fixed, parameterised latency. It owns the word storage, accepts requests with a ready/req handshake, and answers each read with a one-cycle `rvalid` pulse and each write with a one-cycle `wack` pulse. It lets the cache controller be exercised against realistic multi-cycle memory instead of a zero-latency RAM.

## Interface
- `ADDR_W`, 5: word address width; depth = 2**ADDR_W words.
- `DATA_W`, 32: word width.
- `LATENCY`, 3: cycles from accept edge to response edge; legal range 1..15.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  1  request strobe; sampled only while `ready`=1.
- `wr`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  word address; sampled with `req`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `ready`  out  1  high while idle and able to accept.
- `rvalid`  out  1  one-cycle pulse: `rdata` holds the read result.
- `rdata`  out  DATA_W  read data; holds last read result.
- `wack`  out  1  one-cycle pulse: write committed.

## Operation
- States: IDLE, WAIT, DONE. `ready` = (state == IDLE).
- IDLE: on an edge with `req`=1, latch `wr`, `addr`, `wdata`; load counter with LATENCY-1; go to WAIT. With `req`=0, stay.
- WAIT: if counter == 0, perform the access and go to DONE; else decrement.
  - Read access: `rdata` <= mem[addr_q], `rvalid` <= 1.
  - Write access: mem[addr_q] <= wdata_q, `wack` <= 1; `rdata` unchanged.
- DONE: `rvalid`/`wack` return to 0; go to IDLE.
- `req` while not ready is ignored. It is not queued and not an error; the requester must hold or re-issue it.
- Read-after-write to the same address returns the written value; the write commits before DONE.
- Addresses wrap naturally within ADDR_W bits; there are no out-of-range accesses.
- Counter width is 4 bits.

## Timing
- Reset values: state = IDLE, `ready`=1, `rvalid`=0, `wack`=0, `rdata`=0, counter=0, latched request = 0, all memory words = 0.
- Accept edge = edge E where `ready`=1 and `req`=1. `rvalid`/`wack` are high in the cycle after edge E+LATENCY, for exactly one cycle.
- `ready` falls after edge E and rises after edge E+LATENCY+1.
- Earliest next accept is edge E+LATENCY+2. Max throughput is one request per LATENCY+2 cycles.
- LATENCY=1: accept at E, response visible after E+1, `ready` back after E+2.
- `rvalid` and `wack` are never high together and never high for two consecutive cycles.
- Reset asserted mid-transaction returns immediately to IDLE. A pending write is dropped and memory is cleared; no response pulse is produced.
- Inputs need to be stable only around the accept edge; changes during WAIT/DONE have no effect.

## Structure
- Shared package `cache_pkg`: state enum (IDLE/WAIT/DONE), default ADDR_W/DATA_W constants, and the depth derivation shared with the cache.
- One natural sub-module, `resp_mem_array`:
  - synchronous-write, registered-read storage with an async clear;
  - instantiated with ADDR_W/DATA_W.
- FSM, counter and handshake stay in the top module.

## Test plan
- Reset, then idle: `ready`=1, `rvalid`=`wack`=0, `rdata`=0. Read addr 7 -> `rvalid` pulse after LATENCY=3 cycles with `rdata`=0.
- Write 0xDEADBEEF to addr 5 -> `wack` pulse exactly 3 cycles after accept, `ready` low 4 cycles. Then read addr 5 -> `rdata`=0xDEADBEEF with `rvalid`.
- Back-to-back: hold `req`=1, alternating write 0x1 to addr 0 and read addr 0. Accepts occur every 5 cycles; the read returns 0x1; no request is lost or duplicated.
- `req` pulsed while busy (write to addr 3 during WAIT) -> ignored; a later read of addr 3 returns 0.
- Reset asserted during WAIT of a write of 0x55 to addr 9 -> no `wack`, `ready`=1 at once; a later read of addr 9 returns 0.
- Parameter sweep LATENCY=1 and LATENCY=15: response edge is E+LATENCY and `ready` returns at E+LATENCY+1. Address wrap: write addr 31, then read addr 31 returns the data.
